// File: rtl/bcd_serial_addsub_if.sv
// Operand/result bundle for the digit-serial BCD adder/subtractor.
// The master side issues operations; the slave side (the datapath) returns results.
interface bcd_serial_addsub_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic                  sub;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  carryIn;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   sum;
    logic                  carryOut;
    logic                  invalid;

    modport master (
        output start, sub, a, b, carryIn,
        input  busy, done, sum, carryOut, invalid
    );

    modport slave (
        input  start, sub, a, b, carryIn,
        output busy, done, sum, carryOut, invalid
    );
endinterface

// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor: one decimal digit per clock, LSD first,
// with a registered inter-digit carry and a start/busy/done handshake.
module bcd_serial_addsub #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    bcd_serial_addsub_if.slave    bus
);
    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [W-1:0]      sum_q, sum_d;
    logic              sub_q, sub_d;
    logic              carry_q, carry_d;
    logic              inv_pend_q, inv_pend_d;
    logic              cout_q, cout_d;
    logic              invalid_q, invalid_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    logic [DIGITS-1:0] digit_bad;
    logic [3:0]        ad, bd_raw, bd, rd;
    logic [4:0]        t;
    logic              carry_nxt;
    logic              last_digit;

    // Any non-decimal nibble in either incoming operand poisons the whole result.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_chk
        assign digit_bad[gi] = (bus.a[4*gi +: 4] > 4'd9) | (bus.b[4*gi +: 4] > 4'd9);
    end

    always_comb begin
        ad     = 4'd0;
        bd_raw = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                ad     = a_q[4*i +: 4];
                bd_raw = b_q[4*i +: 4];
            end
        end
        // Subtraction adds the nines' complement; the carry seed supplies the +1.
        bd = sub_q ? (4'd9 - bd_raw) : bd_raw;
        t  = {1'b0, ad} + {1'b0, bd} + {4'b0, carry_q};
        if (t > 5'd9) begin
            rd        = t[3:0] + 4'd6;
            carry_nxt = 1'b1;
        end else begin
            rd        = t[3:0];
            carry_nxt = 1'b0;
        end
        last_digit = (idx_q == IDX_W'(DIGITS - 1));
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sum_d      = sum_q;
        sub_d      = sub_q;
        carry_d    = carry_q;
        inv_pend_d = inv_pend_q;
        cout_d     = cout_q;
        invalid_d  = invalid_q;
        idx_d      = idx_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    state_d    = RUN;
                    a_d        = bus.a;
                    b_d        = bus.b;
                    sub_d      = bus.sub;
                    idx_d      = '0;
                    carry_d    = bus.sub ? ~bus.carryIn : bus.carryIn;
                    inv_pend_d = |digit_bad;
                    sum_d      = '0;
                    cout_d     = 1'b0;
                end
            end
            RUN: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[4*i +: 4] = rd;
                    end
                end
                carry_d = carry_nxt;
                idx_d   = idx_q + IDX_W'(1);
                if (last_digit) begin
                    state_d   = DONE;
                    idx_d     = '0;
                    cout_d    = sub_q ? ~carry_nxt : carry_nxt;
                    invalid_d = inv_pend_q;
                    if (inv_pend_q) begin
                        sum_d  = '0;
                        cout_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            sub_q      <= 1'b0;
            carry_q    <= 1'b0;
            inv_pend_q <= 1'b0;
            cout_q     <= 1'b0;
            invalid_q  <= 1'b0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sum_q      <= sum_d;
            sub_q      <= sub_d;
            carry_q    <= carry_d;
            inv_pend_q <= inv_pend_d;
            cout_q     <= cout_d;
            invalid_q  <= invalid_d;
            idx_q      <= idx_d;
        end
    end

    assign bus.busy     = (state_q == RUN);
    assign bus.done     = (state_q == DONE);
    assign bus.sum      = sum_q;
    assign bus.carryOut = cout_q;
    assign bus.invalid  = invalid_q;
endmodule
